// File: rtl/syn_fifo_pkg.sv
// Shared types and default sizing for the synchronous FIFO read-side logic.
package syn_fifo_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/syn_fifo_skid2.sv
// Two-entry ordered buffer: words leave from the head in arrival order.
module syn_fifo_skid2
  import syn_fifo_pkg::*;
#(
  parameter int unsigned width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output occ_e             occ,
  output logic [width-1:0] head
);

  occ_e             occ_q, occ_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;

  // push_data is only looked at when push is set; it may be undriven otherwise
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      EMPTY: begin
        if (push) begin
          head_d = push_data;
          occ_d  = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b11: head_d = push_data;
          2'b10: begin
            tail_d = push_data;
            occ_d  = TWO;
          end
          2'b01: occ_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
          else      occ_d  = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/syn_fifo_reader.sv
// Drains a one-cycle-latency synchronous FIFO onto a valid/ready stream at full rate.
module syn_fifo_reader
  import syn_fifo_pkg::*;
#(
  parameter int fifo_depth = FIFO_DEPTH_DEF,
  parameter int fifo_width = $clog2(fifo_depth),
  parameter int cnt_width  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  emp_fg,
  input  logic [fifo_width-1:0] rdata,
  output logic                  rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [fifo_width-1:0] out_data,
  output logic [cnt_width-1:0]  out_count,
  output logic                  busy
);

  occ_e                  occ;
  logic [fifo_width-1:0] head;
  logic                  pend_q, pend_d;
  logic [cnt_width-1:0]  count_q, count_d;
  logic                  pop;
  logic [2:0]            load;

  assign out_valid = (occ != EMPTY);
  assign pop       = out_valid && out_ready;

  // Slots committed after this cycle; pop frees one now, so ready feeds rd_en combinationally
  always_comb begin
    load    = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
    rd_en   = !rst && !emp_fg && (load < 3'd2);
    pend_d  = rd_en && !emp_fg;
    count_d = pop ? count_q + cnt_width'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  syn_fifo_skid2 #(
    .width (fifo_width)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_q),
    .push_data (rdata),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign out_data  = head;
  assign out_count = count_q;
  assign busy      = (occ != EMPTY) || pend_q;

endmodule
